osd_mam_burst_splitter: RTL
===========================

// Module: osd_mam_burst_splitter
// PURPOSE
// - Sits between the MAM request/data source and osd_mam_wb_if; feeds its req_*/write_*/read_* handshakes.
// - Splits one upstream burst (up to 16383 beats) into chunks of at most MAX_BEATS beats that never cross a BOUNDARY-byte address window.
// - Data is passed through between chunks and beats are counted so the next chunk request is issued only after the current chunk completes.
// PARAMETERS
// - DATA_WIDTH  16    word width in bits, multiple of 16; BPW = DATA_WIDTH/8 bytes per word
// - ADDR_WIDTH  32    byte address width
// - MAX_BEATS   16    max beats per downstream chunk, 1..8191
// - BOUNDARY    1024  byte window a chunk must not cross; power of two, >= BPW
// PORTS
// - clk_i  in  1  clock
// - rst_i  in  1  synchronous active-high reset
// - in_req_valid/in_req_ready  in/out  1/1  upstream request handshake
// - in_req_rw, in_req_burst  in  1  0 read/1 write; 0 single/1 incr burst
// - in_req_addr  in  ADDR_WIDTH  base byte address, BPW-aligned
// - in_req_beats  in  14  total beats
// - out_req_valid/out_req_ready  out/in  1/1  chunk request to osd_mam_wb_if
// - out_req_rw, out_req_burst  out  1  copied from latched request
// - out_req_addr  out  ADDR_WIDTH  chunk base address
// - out_req_beats  out  14  chunk length
// - in_write_valid/in_write_ready  in/out  1  upstream write data handshake
// - in_write_data, in_write_strb  in  DATA_WIDTH, DATA_WIDTH/8  write word, byte strobe
// - out_write_valid/out_write_ready  out/in  1  downstream write handshake
// - out_write_data, out_write_strb  out  DATA_WIDTH, DATA_WIDTH/8  pass-through
// - out_read_valid/out_read_ready  in/out  1  downstream read handshake
// - out_read_data  in  DATA_WIDTH  read word from wb_if
// - in_read_valid/in_read_ready  out/in  1  upstream read handshake
// - in_read_data  out  DATA_WIDTH  pass-through
// BEHAVIOUR
// - Reset: state IDLE; out_req_valid=0, in_req_ready=1, all gated valid/ready outputs 0; counters 0.
// - FSM IDLE -> ISSUE -> XFER -> (ISSUE | IDLE).
// - IDLE: in_req_ready=1; on in_req_valid latch rw, burst, addr; rem = burst ? max(beats,1) : 1; goto ISSUE.
// - Chunk length clen = min(rem, MAX_BEATS, (BOUNDARY - addr%BOUNDARY)/BPW); burst=0 => clen=1.
// - ISSUE: out_req_valid=1 (registered; first assertion the cycle after in_req acceptance); fields stable until out_req_ready; on ready: cleft=clen, goto XFER.
// - XFER: combinational pass-through write in->out and read out->in; each completed handshake decrements cleft (write: out_write_valid&out_write_ready; read: out_read_valid&out_read_ready).
// - Last beat of chunk (cleft==1 and handshake): rem-=clen, addr+=clen*BPW (wraps modulo 2^ADDR_WIDTH); rem==0 -> IDLE, else ISSUE.
// - Outside XFER: in_write_ready, out_write_valid, in_read_valid, out_read_ready forced 0; data ports still pass through.
// - Only the stream matching rw is enabled in XFER; the other stays gated 0.
// - Next chunk request is never asserted before the previous chunk's final beat handshake.
// - in_req_beats=0 with burst=1 is treated as 1 beat.
// - Reset mid-operation: immediate return to IDLE, in-flight transfer abandoned, no further out_req_valid.
// CONFIGURATION
// - OSD_MAM_SPLIT_STATS_EN defined: add output chunk_count[15:0], +1 per accepted out_req handshake, saturating at 16'hFFFF, cleared by rst_i.
// - OSD_MAM_SPLIT_STATS_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
// - Write addr=0x0, beats=40, MAX_BEATS=16 -> chunks (0x000,16),(0x020,16),(0x040,8) with DATA_WIDTH=16; in_write_ready pulses 40 times total.
// - Read addr=0x3F0, beats=20, BOUNDARY=1024, DATA_WIDTH=16 -> chunks (0x3F0,8),(0x400,12); 20 words delivered in order.
// - Single write burst=0, beats=7 -> one chunk beats=1 burst=0; strobe 2'b01 reaches out_write_strb unchanged.
// - out_req_ready held 0 for 5 cycles in ISSUE -> addr/beats/rw stable throughout; no data handshakes occur.
// - rst_i asserted mid-XFER of 2nd chunk -> next cycle IDLE, in_req_ready=1, out_req_valid=0, data gates 0.
// - STATS_EN: 3 requests of 40 beats -> chunk_count=9; reset -> 0.

Source files
------------

// File: rtl/osd_mam_burst_splitter.sv
// Splits MAM bursts into MAX_BEATS-limited, BOUNDARY-aligned wishbone chunks.
// Optional chunk statistics counter: define OSD_MAM_SPLIT_STATS_EN.
module osd_mam_burst_splitter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int BOUNDARY   = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_req_valid,
  output logic                    in_req_ready,
  input  logic                    in_req_rw,
  input  logic                    in_req_burst,
  input  logic [ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [13:0]             in_req_beats,
  output logic                    out_req_valid,
  input  logic                    out_req_ready,
  output logic                    out_req_rw,
  output logic                    out_req_burst,
  output logic [ADDR_WIDTH-1:0]   out_req_addr,
  output logic [13:0]             out_req_beats,
  input  logic                    in_write_valid,
  output logic                    in_write_ready,
  input  logic [DATA_WIDTH-1:0]   in_write_data,
  input  logic [DATA_WIDTH/8-1:0] in_write_strb,
  output logic                    out_write_valid,
  input  logic                    out_write_ready,
  output logic [DATA_WIDTH-1:0]   out_write_data,
  output logic [DATA_WIDTH/8-1:0] out_write_strb,
  input  logic                    out_read_valid,
  output logic                    out_read_ready,
  input  logic [DATA_WIDTH-1:0]   out_read_data,
  output logic                    in_read_valid,
  input  logic                    in_read_ready,
  output logic [DATA_WIDTH-1:0]   in_read_data
`ifdef OSD_MAM_SPLIT_STATS_EN
  ,
  output logic [15:0]             chunk_count
`endif
);

  localparam int BPW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER
  } state_t;

  state_t state_q, state_d;

  logic                  rw_q;
  logic                  burst_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [13:0]           rem_q;
  logic [13:0]           cleft_q;
  logic [13:0]           clen;
  logic [13:0]           rem_next;
  logic [31:0]           off;
  logic [31:0]           win;
  logic [31:0]           c;
  logic                  xfer;
  logic                  beat;
  logic                  last;

  // Chunk length: remaining beats, capped by MAX_BEATS and the window end
  always_comb begin
    off = 32'(addr_q & ADDR_WIDTH'(BOUNDARY - 1));
    win = (32'(BOUNDARY) - off) / 32'(BPW);
    c   = 32'(rem_q);
    if (c > 32'(MAX_BEATS)) c = 32'(MAX_BEATS);
    if (c > win) c = win;
    if (!burst_q) c = 32'd1;
    clen = c[13:0];
  end

  assign xfer = (state_q == XFER);

  assign out_write_valid = xfer & rw_q & in_write_valid;
  assign in_write_ready  = xfer & rw_q & out_write_ready;
  assign in_read_valid   = xfer & ~rw_q & out_read_valid;
  assign out_read_ready  = xfer & ~rw_q & in_read_ready;

  assign out_write_data = in_write_data;
  assign out_write_strb = in_write_strb;
  assign in_read_data   = out_read_data;

  assign beat = rw_q ? (out_write_valid & out_write_ready)
                     : (in_read_valid & out_read_ready);
  assign last     = beat && (cleft_q == 14'd1);
  assign rem_next = rem_q - clen;

  assign in_req_ready  = (state_q == IDLE);
  assign out_req_valid = (state_q == ISSUE);
  assign out_req_rw    = rw_q;
  assign out_req_burst = burst_q;
  assign out_req_addr  = addr_q;
  assign out_req_beats = clen;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_req_valid) state_d = ISSUE;
      ISSUE: if (out_req_ready) state_d = XFER;
      XFER:  if (last) state_d = (rem_next == 14'd0) ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rw_q    <= 1'b0;
      burst_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      cleft_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_req_valid) begin
          rw_q    <= in_req_rw;
          burst_q <= in_req_burst;
          addr_q  <= in_req_addr;
          if (!in_req_burst)             rem_q <= 14'd1;
          else if (in_req_beats == 14'd0) rem_q <= 14'd1;
          else                           rem_q <= in_req_beats;
        end
        ISSUE: if (out_req_ready) cleft_q <= clen;
        XFER: if (beat) begin
          cleft_q <= cleft_q - 14'd1;
          if (last) begin
            rem_q  <= rem_next;
            addr_q <= addr_q + ADDR_WIDTH'(clen) * ADDR_WIDTH'(BPW);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OSD_MAM_SPLIT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      chunk_count <= '0;
    else if (out_req_valid && out_req_ready && chunk_count != 16'hFFFF)
      chunk_count <= chunk_count + 16'd1;
  end
`endif

endmodule
